// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: replays round keys 10..0 from the last key.
// Optional abort input is enabled by defining INVKEY_ABORT_EN.
module inv_key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key_in,
    input  logic         key_ready,
`ifdef INVKEY_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [7:0] sbox [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  rot, sub;
    logic [127:0] prev_key;
    logic         xfer;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Words 1..3 unwind first; word 0 then needs the recovered word 3.
    assign n3  = w3 ^ w2;
    assign n2  = w2 ^ w1;
    assign n1  = w1 ^ w0;
    assign rot = {n3[23:0], n3[31:24]};
    assign sub = {sbox[rot[31:24]], sbox[rot[23:16]],
                  sbox[rot[15:8]],  sbox[rot[7:0]]};
    assign n0  = w0 ^ sub ^ {rcon(idx_q), 24'h0};

    assign prev_key = {n0, n1, n2, n3};

    assign busy      = (state_q == EMIT);
    assign key_valid = busy;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign done      = done_q;
    assign xfer      = key_valid & key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = last_key_in;
                    idx_d   = 4'd10;
                    state_d = EMIT;
                end
            end
            EMIT: begin
`ifdef INVKEY_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                end else
`endif
                if (xfer) begin
                    if (idx_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed bench for inv_key_expansion using the FIPS-197 A.1 schedule.
// Abort scenario is exercised only when INVKEY_ABORT_EN is defined.
module tb_inv_key_expansion;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] last_key_in;
    logic         key_ready;
`ifdef INVKEY_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         done;

    vec_t vec [0:10];
    int   n_vec;
    int   n_err;

    inv_key_expansion dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .last_key_in (last_key_in),
        .key_ready   (key_ready),
`ifdef INVKEY_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .key_valid   (key_valid),
        .round_key   (round_key),
        .round_idx   (round_idx),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_kv"},   128'(key_valid), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_idx"},  128'(round_idx), 128'(0));
        chk({tag, "_key"},  round_key, 128'(0));
    endtask

    task automatic run_fips(input string tag);
        key_ready   = 1'b1;
        last_key_in = vec[0].key;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk({tag, "_kv"},   128'(key_valid), 128'(1));
            chk({tag, "_busy"}, 128'(busy), 128'(1));
            chk({tag, "_idx"},  128'(round_idx), 128'(vec[i].idx));
            chk({tag, "_key"},  round_key, vec[i].key);
            chk({tag, "_nodone"}, 128'(done), 128'(0));
            tick();
        end
        chk({tag, "_done"},    128'(done), 128'(1));
        chk({tag, "_endbusy"}, 128'(busy), 128'(0));
        chk({tag, "_endkv"},   128'(key_valid), 128'(0));
        chk({tag, "_holdkey"}, round_key, vec[10].key);
    endtask

    initial begin
        vec[0]  = '{4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
        vec[1]  = '{4'd9,  128'hac7766f3_19fadc21_28d12941_575c006e};
        vec[2]  = '{4'd8,  128'head27321_b58dbad2_312bf560_7f8d292f};
        vec[3]  = '{4'd7,  128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f};
        vec[4]  = '{4'd6,  128'h6d88a37a_110b3efd_dbf98641_ca0093fd};
        vec[5]  = '{4'd5,  128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc};
        vec[6]  = '{4'd4,  128'hef44a541_a8525b7f_b671253b_db0bad00};
        vec[7]  = '{4'd3,  128'h3d80477d_4716fe3e_1e237e44_6d7a883b};
        vec[8]  = '{4'd2,  128'hf2c295f2_7a96b943_5935807a_7359f67f};
        vec[9]  = '{4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605};
        vec[10] = '{4'd0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};

        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        start       = 1'b0;
        key_ready   = 1'b0;
        last_key_in = '0;
`ifdef INVKEY_ABORT_EN
        abort       = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("rst");

        // Straight run with key_ready held high.
        run_fips("fips");
        tick();
        chk("done_pulse", 128'(done), 128'(0));

        // Random backpressure: outputs must track vec[e] every cycle.
        begin
            int e;
            logic r;
            e = 0;
            key_ready   = 1'b0;
            last_key_in = vec[0].key;
            start       = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 200 && e < 11; c++) begin
                chk("bp_kv",  128'(key_valid), 128'(1));
                chk("bp_idx", 128'(round_idx), 128'(vec[e].idx));
                chk("bp_key", round_key, vec[e].key);
                r = 1'($urandom_range(0, 1));
                key_ready = r;
                tick();
                if (r) e++;
            end
            chk("bp_count", 128'(e), 128'(11));
            chk("bp_done",  128'(done), 128'(1));
            chk("bp_busy",  128'(busy), 128'(0));
        end

        // Start asserted while busy at idx 5 is ignored.
        key_ready   = 1'b1;
        last_key_in = vec[0].key;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("sb_idx", 128'(round_idx), 128'(vec[i].idx));
            chk("sb_key", round_key, vec[i].key);
            if (vec[i].idx == 4'd5) begin
                start       = 1'b1;
                last_key_in = 128'h01234567_89abcdef_fedcba98_76543210;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("sb_done", 128'(done), 128'(1));
        tick();
        chk("sb_idle", 128'(busy), 128'(0));

        // Mid-session reset at idx 4.
        last_key_in = vec[0].key;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && round_idx != 4'd4; c++) tick();
        chk("mr_at4", 128'(round_idx), 128'(4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("mr");
        tick();
        chk("mr_nodone", 128'(done), 128'(0));
        run_fips("rerun");

        // Back-to-back: start on the done cycle with an all-zero key.
        last_key_in = '0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_kv",   128'(key_valid), 128'(1));
        chk("b2b_idx",  128'(round_idx), 128'(10));
        chk("b2b_key",  round_key, 128'(0));
        tick();
        chk("b2b_idx9", 128'(round_idx), 128'(9));
        chk("b2b_key9", round_key,
            128'h55636363_00000000_00000000_00000000);
        repeat (10) tick();
        chk("b2b_done", 128'(done), 128'(1));
        chk("b2b_busy", 128'(busy), 128'(0));

`ifdef INVKEY_ABORT_EN
        last_key_in = vec[0].key;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && round_idx != 4'd7; c++) tick();
        chk("ab_at7", 128'(round_idx), 128'(7));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_kv",   128'(key_valid), 128'(0));
        chk("ab_busy", 128'(busy), 128'(0));
        chk("ab_done", 128'(done), 128'(0));
        tick();
        chk("ab_done2", 128'(done), 128'(0));
        run_fips("ab_rerun");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
